// File: rtl/key_sched_seq_128_if.sv
// key_sched_seq_128_if: control, round-key stream, word-generator and store-read signals.
// master is the environment side, slave is the key-schedule controller.
interface key_sched_seq_128_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_index;
  logic [127:0] rk_data;
  logic [5:0]   gen_i;
  logic [31:0]  gen_prev_word;
  logic [31:0]  gen_prev_period_word;
  logic [31:0]  gen_current_word;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  modport master (
    output start, key_in, rk_ready, gen_current_word, rd_addr,
    input  busy, done, rk_valid, rk_index, rk_data, gen_i, gen_prev_word,
           gen_prev_period_word, rd_data
  );
  modport slave (
    input  start, key_in, rk_ready, gen_current_word, rd_addr,
    output busy, done, rk_valid, rk_index, rk_data, gen_i, gen_prev_word,
           gen_prev_period_word, rd_data
  );
endinterface

// File: rtl/key_sched_seq_128.sv
// key_sched_seq_128: sequential AES-128 key schedule, one generated word per cycle, round keys streamed out.
// Define KEY_SCHED_STORE_EN to add an 11-entry round-key store with a registered read port.
module key_sched_seq_128 #(
  parameter int NUM_ROUNDS = 10
) (
  input logic               clk,
  input logic               rst_n,
  key_sched_seq_128_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT, GEN} state_t;
  state_t       state, state_nx;
  logic [127:0] window, window_nx, rk_data_nx;
  logic [3:0]   r, r_nx, rk_index_nx;
  logic [1:0]   k, k_nx;
  logic         busy_nx, done_nx, rk_valid_nx;
  assign bus.gen_prev_period_word = window[127:96];
  assign bus.gen_prev_word        = window[31:0];
  // {r, k} is exactly 4*r + k
  assign bus.gen_i = (state == GEN) ? {r, k} : 6'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      window       <= '0;
      r            <= '0;
      k            <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rk_valid <= 1'b0;
      bus.rk_index <= '0;
      bus.rk_data  <= '0;
    end else begin
      state        <= state_nx;
      window       <= window_nx;
      r            <= r_nx;
      k            <= k_nx;
      bus.busy     <= busy_nx;
      bus.done     <= done_nx;
      bus.rk_valid <= rk_valid_nx;
      bus.rk_index <= rk_index_nx;
      bus.rk_data  <= rk_data_nx;
    end
  end
  always_comb begin
    state_nx    = state;
    window_nx   = window;
    r_nx        = r;
    k_nx        = k;
    busy_nx     = bus.busy;
    done_nx     = 1'b0;
    rk_valid_nx = bus.rk_valid;
    rk_index_nx = bus.rk_index;
    rk_data_nx  = bus.rk_data;
    case (state)
      IDLE: if (bus.start) begin
        window_nx   = bus.key_in;
        r_nx        = '0;
        rk_data_nx  = bus.key_in;
        rk_index_nx = '0;
        rk_valid_nx = 1'b1;
        busy_nx     = 1'b1;
        state_nx    = EMIT;
      end
      EMIT: if (bus.rk_ready) begin
        rk_valid_nx = 1'b0;
        if (r == 4'(NUM_ROUNDS)) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          r_nx     = r + 4'd1;
          k_nx     = '0;
          state_nx = GEN;
        end
      end
      GEN: begin
        window_nx = {window[95:0], bus.gen_current_word};
        k_nx      = k + 2'd1;
        if (k == 2'd3) begin
          rk_data_nx  = window_nx;
          rk_index_nx = r;
          rk_valid_nx = 1'b1;
          state_nx    = EMIT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
`ifdef KEY_SCHED_STORE_EN
  logic [127:0] store [0:10];
  logic         store_we;
  // a round key is captured on the cycle it enters EMIT
  assign store_we = (state_nx == EMIT) && (state != EMIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
      bus.rd_data <= '0;
    end else begin
      if (store_we) store[rk_index_nx] <= rk_data_nx;
      bus.rd_data <= (bus.rd_addr <= 4'd10) ? store[bus.rd_addr] : '0;
    end
  end
`else
  assign bus.rd_data = '0;
`endif
endmodule

// File: tb/tb_key_sched_seq_128.sv
// tb_key_sched_seq_128: scoreboard bench for key_sched_seq_128 with a behavioural AES word generator.
// Honours KEY_SCHED_STORE_EN for the store read-back checks.
module tb_key_sched_seq_128;
  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10_B = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int hs = 0;
  logic [131:0] sb [$];
  logic [131:0] mon_exp;
  logic [31:0]  gw [44];
  logic [127:0] last_rk = '0;

  key_sched_seq_128_if bus();
  key_sched_seq_128 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int j = 0; j < 8; j++) begin
      if (b[j]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = '0;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] gen_word(input logic [5:0] i, input logic [31:0] p, input logic [31:0] pp);
    logic [31:0] t;
    logic [7:0]  rc;
    t = p;
    if (i[1:0] == 2'd0) begin
      rc = 8'h01;
      for (int j = 1; j < int'(i[5:2]); j++) rc = xtime(rc);
      t = {sbox(p[23:16]), sbox(p[15:8]), sbox(p[7:0]), sbox(p[31:24])} ^ {rc, 24'h0};
    end
    return pp ^ t;
  endfunction

  assign bus.gen_current_word = gen_word(bus.gen_i, bus.gen_prev_word, bus.gen_prev_period_word);

  always @(negedge clk) begin
    if (rst_n && bus.rk_valid && bus.rk_ready) begin
      hs++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got idx=%0d data=%h expected none", bus.rk_index, bus.rk_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({bus.rk_index, bus.rk_data} !== mon_exp) begin
          failures++;
          $display("FAIL sb_round got=%h expected=%h", {bus.rk_index, bus.rk_data}, mon_exp);
        end
      end
      last_rk = bus.rk_data;
    end
  end

  task automatic expand(input logic [127:0] key);
    {gw[0], gw[1], gw[2], gw[3]} = key;
    for (int i = 4; i < 44; i++) gw[i] = gen_word(6'(i), gw[i-1], gw[i-4]);
  endtask

  task automatic push_sched(input logic [127:0] key);
    expand(key);
    for (int r = 0; r <= 10; r++) sb.push_back({4'(r), gw[4*r], gw[4*r+1], gw[4*r+2], gw[4*r+3]});
  endtask

  task automatic start_sched(input logic [127:0] key);
    push_sched(key);
    @(posedge clk); #1 bus.start = 1'b1; bus.key_in = key;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = bus.done;
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0; bus.rd_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rk_valid, bus.rk_index, bus.gen_i} !== 13'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h expected=0", {bus.busy, bus.done, bus.rk_valid, bus.rk_index, bus.gen_i});
    end
    checks++;
    if (bus.rk_data !== '0) begin failures++; $display("FAIL reset_rk_data got=%h expected=0", bus.rk_data); end
    checks++;
    if ({bus.gen_prev_word, bus.gen_prev_period_word} !== 64'd0) begin
      failures++; $display("FAIL reset_window got=%h expected=0", {bus.gen_prev_word, bus.gen_prev_period_word});
    end
    checks++;
    if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h expected=0", bus.rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int hs0;
    bit ev;
    hs0 = hs;
    bus.rk_ready = 1'b1;
    start_sched(KEY_A);
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      ev = (n <= 51) && ((n - 1) % 5 == 0);
      checks++;
      if (bus.rk_valid !== ev) begin failures++; $display("FAIL basic_valid cycle=%0d got=%b expected=%b", n, bus.rk_valid, ev); end
      checks++;
      if (bus.busy !== (n <= 51)) begin failures++; $display("FAIL basic_busy cycle=%0d got=%b expected=%b", n, bus.busy, n <= 51); end
      checks++;
      if (bus.done !== (n == 52)) begin failures++; $display("FAIL basic_done cycle=%0d got=%b expected=%b", n, bus.done, n == 52); end
      if (n == 1) begin
        checks++;
        if ({bus.rk_index, bus.rk_data} !== {4'd0, KEY_A}) begin failures++; $display("FAIL basic_round0 got=%h expected=%h", bus.rk_data, KEY_A); end
      end
      if (n == 6) begin
        checks++;
        if ({bus.rk_index, bus.rk_data} !== {4'd1, RK1_A}) begin failures++; $display("FAIL basic_round1 got=%h expected=%h", bus.rk_data, RK1_A); end
      end
      if (n == 51) begin
        checks++;
        if ({bus.rk_index, bus.rk_data} !== {4'd10, RK10_A}) begin failures++; $display("FAIL basic_round10 got=%h expected=%h", bus.rk_data, RK10_A); end
      end
    end
    checks++;
    if (hs - hs0 != 11 || sb.size() != 0) begin failures++; $display("FAIL basic_handshakes got=%0d left=%0d expected=11", hs - hs0, sb.size()); end
  endtask

  task automatic test_gen_sequence;
    int ei;
    bit ok;
    ei = 4; ok = 1'b0;
    bus.rk_ready = 1'b1;
    start_sched(KEY_A);
    for (int c = 0; c < 80 && !ok; c++) begin
      @(negedge clk);
      ok = bus.done;
      if (bus.busy && !bus.rk_valid && ei < 44) begin
        checks++;
        if (bus.gen_i !== 6'(ei)) begin failures++; $display("FAIL gen_i got=%0d expected=%0d", bus.gen_i, ei); end
        checks++;
        if (bus.gen_prev_period_word !== gw[ei-4] || bus.gen_prev_word !== gw[ei-1]) begin
          failures++; $display("FAIL gen_words i=%0d got=%h/%h expected=%h/%h", ei, bus.gen_prev_period_word, bus.gen_prev_word, gw[ei-4], gw[ei-1]);
        end
        ei++;
      end else begin
        checks++;
        if (bus.gen_i !== 6'd0) begin failures++; $display("FAIL gen_i_idle got=%0d expected=0", bus.gen_i); end
      end
    end
    checks++;
    if (ei != 44 || !ok) begin failures++; $display("FAIL gen_count got=%0d done=%b expected=44 done=1", ei, ok); end
  endtask

  task automatic test_backpressure;
    int hs0, stall;
    bit ok, pv, pr;
    logic [131:0] pd;
    hs0 = hs; stall = 0; ok = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
    bus.rk_ready = 1'b0;
    start_sched(KEY_A);
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk); #1;
      if (bus.rk_valid && bus.rk_index == 4'd4 && stall < 7) begin
        bus.rk_ready = 1'b0;
        stall++;
      end else bus.rk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = bus.done;
      if (pv && !pr) begin
        checks++;
        if ({bus.rk_valid, bus.rk_index, bus.rk_data} !== {1'b1, pd}) begin
          failures++; $display("FAIL stall_hold got=%h expected=%h", {bus.rk_valid, bus.rk_index, bus.rk_data}, {1'b1, pd});
        end
        checks++;
        if (bus.gen_i !== 6'd0) begin failures++; $display("FAIL stall_gen_i got=%0d expected=0", bus.gen_i); end
      end
      pv = bus.rk_valid; pr = bus.rk_ready; pd = {bus.rk_index, bus.rk_data};
    end
    bus.rk_ready = 1'b1;
    checks++;
    if (!ok || stall != 7 || hs - hs0 != 11 || sb.size() != 0) begin
      failures++; $display("FAIL bp_complete got done=%b stall=%0d hs=%0d left=%0d expected 1/7/11/0", ok, stall, hs - hs0, sb.size());
    end
  endtask

  task automatic test_start_ignored;
    int hs0;
    bit ok, pulsed;
    hs0 = hs; ok = 1'b0; pulsed = 1'b0;
    bus.rk_ready = 1'b1;
    start_sched(KEY_A);
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = bus.done;
      if (!pulsed && bus.rk_valid && bus.rk_index == 4'd3) begin
        pulsed = 1'b1;
        @(posedge clk); #1 bus.start = 1'b1; bus.key_in = KEY_B;
        @(posedge clk); #1 bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL ignored_busy got=%b expected=1", bus.busy); end
      end
    end
    checks++;
    if (!ok || !pulsed || hs - hs0 != 11 || sb.size() != 0) begin
      failures++; $display("FAIL ignored_complete got done=%b hs=%0d left=%0d expected 1/11/0", ok, hs - hs0, sb.size());
    end
    hs0 = hs;
    start_sched(KEY_B);
    wait_done(ok);
    checks++;
    if (!ok || last_rk !== RK10_B || hs - hs0 != 11) begin
      failures++; $display("FAIL key_b_round10 got=%h hs=%0d expected=%h hs=11", last_rk, hs - hs0, RK10_B);
    end
  endtask

  task automatic test_back_to_back;
    int hs0;
    bit ok;
    hs0 = hs; ok = 1'b0;
    bus.rk_ready = 1'b1;
    start_sched(KEY_A);
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = bus.rk_valid && bus.rk_index == 4'd10;
    end
    push_sched(KEY_B);
    @(posedge clk); #1 bus.start = 1'b1; bus.key_in = KEY_B;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b expected=1", bus.done); end
    @(posedge clk); #1 bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.rk_valid, bus.rk_index} !== {2'b11, 4'd0}) begin
      failures++; $display("FAIL b2b_restart got=%b expected=110000", {bus.busy, bus.rk_valid, bus.rk_index});
    end
    wait_done(ok);
    checks++;
    if (!ok || hs - hs0 != 22 || sb.size() != 0 || last_rk !== RK10_B) begin
      failures++; $display("FAIL b2b_complete got done=%b hs=%0d left=%0d last=%h expected 1/22/0/%h", ok, hs - hs0, sb.size(), last_rk, RK10_B);
    end
  endtask

  task automatic test_reset_mid;
    int hs0;
    bit ok, seen;
    ok = 1'b0; seen = 1'b0;
    bus.rk_ready = 1'b1;
    start_sched(KEY_A);
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = bus.gen_i >= 6'd24 && bus.gen_i < 6'd28;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_reach_round6 got=%b expected=1", ok); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.rk_valid, bus.rk_index, bus.gen_i} !== 13'd0 || bus.rk_data !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got=%h/%h expected=0", {bus.busy, bus.done, bus.rk_valid, bus.rk_index, bus.gen_i}, bus.rk_data);
    end
    checks++;
    if ({bus.gen_prev_word, bus.gen_prev_period_word} !== 64'd0 || bus.rd_data !== '0) begin
      failures++; $display("FAIL mid_reset_data got=%h/%h expected=0", {bus.gen_prev_word, bus.gen_prev_period_word}, bus.rd_data);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL mid_no_done got=%b expected=0", seen); end
    hs0 = hs;
    start_sched(KEY_A);
    wait_done(ok);
    checks++;
    if (!ok || hs - hs0 != 11 || sb.size() != 0 || last_rk !== RK10_A) begin
      failures++; $display("FAIL mid_restart got done=%b hs=%0d left=%0d last=%h expected 1/11/0/%h", ok, hs - hs0, sb.size(), last_rk, RK10_A);
    end
  endtask

  task automatic test_store;
    logic [127:0] exp_rd [4];
    logic [3:0]   addrs [4];
    addrs = '{4'd1, 4'd10, 4'd12, 4'd0};
`ifdef KEY_SCHED_STORE_EN
    exp_rd = '{RK1_A, RK10_A, 128'd0, KEY_A};
`else
    exp_rd = '{128'd0, 128'd0, 128'd0, 128'd0};
`endif
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1 bus.rd_addr = addrs[j];
      @(posedge clk); #1;
      checks++;
      if (bus.rd_data !== exp_rd[j]) begin
        failures++; $display("FAIL store_read addr=%0d got=%h expected=%h", addrs[j], bus.rd_data, exp_rd[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gen_sequence();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
